// File: rtl/ezusb_tx_arbiter_pkg.sv
// Shared types and framing constants for the EZ-USB transmit arbiter.
package ezusb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    TRAILER
  } arb_state_e;

  localparam logic [3:0] HDR_TAG    = 4'hC;
  localparam logic [3:0] TRL_TAG    = 4'hE;
  localparam logic [3:0] TRL_TO_TAG = 4'hF;

  function automatic logic [15:0] frame_word(input logic [3:0] tag,
                                             input logic [3:0] ch,
                                             input logic [7:0] field);
    return {tag, ch, field};
  endfunction

endpackage

// File: rtl/ezusb_tx_arbiter_if.sv
// Requester and slave-FIFO word-stream signals shared by the arbiter and its environment.
interface ezusb_tx_arbiter_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH*16-1:0] req_data;
  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_last;
  logic [NCH-1:0]    req_ready;
  logic [15:0]       DI;
  logic              DI_valid;
  logic              DI_ready;
  logic              DI_enable;

  modport master (
    output req_data, req_valid, req_last, DI_ready,
    input  req_ready, DI, DI_valid, DI_enable
  );

  modport slave (
    input  req_data, req_valid, req_last, DI_ready,
    output req_ready, DI, DI_valid, DI_enable
  );
endinterface

// File: rtl/ezusb_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo NCH.
module rr_select #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [3:0]     ptr,
  output logic [3:0]     idx,
  output logic           any
);
  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [4:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      cand = {1'b0, ptr} + 5'(i);
      if (cand >= 5'(NCH)) cand = cand - 5'(NCH);
      if (!any && req[cand[IW-1:0]]) begin
        idx = cand[3:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ezusb_tx_arbiter.sv
// Round-robin arbiter framing per-channel bursts (header, data, trailer) onto the EZ-USB DI stream.
// Optional stall timeout enabled by defining EZUSB_TX_ARB_TIMEOUT_EN.
module ezusb_tx_arbiter
  import ezusb_pkg::*;
#(
  parameter int unsigned NCH          = 4,
  parameter int unsigned BURST_WORDS  = 256,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic               ifclk,
  input  logic               reset_n,
  ezusb_tx_arbiter_if.slave  bus,
  output logic [3:0]         grant_ch,
  output logic               busy
);

  if (NCH < 1 || NCH > 16 || BURST_WORDS < 1 || BURST_WORDS > 256 || IDLE_TIMEOUT < 1) begin : g_bad_cfg
    $error("ezusb_tx_arbiter: parameter out of range");
  end

  arb_state_e     state_q, state_d;
  logic [3:0]     grant_ch_q, grant_ch_d;
  logic [7:0]     seq_q, seq_d;
  logic [8:0]     wcnt_q, wcnt_d;
  logic           di_enable_q, di_enable_d;
  logic [15:0]    di;
  logic           di_valid;
  logic [NCH-1:0] req_ready;
  logic [15:0]    ch_data;
  logic           ch_valid;
  logic           ch_last;
  logic [3:0]     sel_idx;
  logic           sel_any;
  logic           xfer;
  logic [3:0]     trl_tag;
  logic [7:0]     cnt_field;
`ifdef EZUSB_TX_ARB_TIMEOUT_EN
  logic [15:0]    stall_q, stall_d;
  logic           timed_out_q, timed_out_d;
`endif

  rr_select #(.NCH(NCH)) u_rr (
    .req (bus.req_valid),
    .ptr (grant_ch_q),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_comb begin
    ch_data  = '0;
    ch_valid = 1'b0;
    ch_last  = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (grant_ch_q == 4'(c)) begin
        ch_data  = bus.req_data[16*c +: 16];
        ch_valid = bus.req_valid[c];
        ch_last  = bus.req_last[c];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_ch_d  = grant_ch_q;
    seq_d       = seq_q;
    wcnt_d      = wcnt_q;
    di_enable_d = (state_q != IDLE) || (|bus.req_valid);
    di          = '0;
    di_valid    = 1'b0;
    req_ready   = '0;
    xfer        = 1'b0;
    trl_tag     = TRL_TAG;
    // Wraps to 8'hFF when no data word was sent (timeout before first word).
    cnt_field   = 8'(wcnt_q - 9'd1);
`ifdef EZUSB_TX_ARB_TIMEOUT_EN
    stall_d     = stall_q;
    timed_out_d = timed_out_q;
    if (timed_out_q) trl_tag = TRL_TO_TAG;
`endif
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          grant_ch_d = sel_idx;
          wcnt_d     = '0;
          state_d    = HEADER;
`ifdef EZUSB_TX_ARB_TIMEOUT_EN
          timed_out_d = 1'b0;
`endif
        end
      end
      HEADER: begin
        di       = frame_word(HDR_TAG, grant_ch_q, seq_q);
        di_valid = 1'b1;
        if (bus.DI_ready) begin
          seq_d   = seq_q + 8'd1;
          state_d = DATA;
`ifdef EZUSB_TX_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end
      DATA: begin
        di       = ch_data;
        di_valid = ch_valid;
        for (int unsigned c = 0; c < NCH; c++) begin
          req_ready[c] = (grant_ch_q == 4'(c)) && bus.DI_ready;
        end
        xfer = ch_valid && bus.DI_ready;
        if (xfer) begin
          wcnt_d = wcnt_q + 9'd1;
          if (ch_last || (wcnt_q + 9'd1 == 9'(BURST_WORDS))) state_d = TRAILER;
        end
`ifdef EZUSB_TX_ARB_TIMEOUT_EN
        if (xfer) begin
          stall_d = '0;
        end else if (!ch_valid) begin
          if (stall_q + 16'd1 == 16'(IDLE_TIMEOUT)) begin
            stall_d     = '0;
            timed_out_d = 1'b1;
            state_d     = TRAILER;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
`endif
      end
      TRAILER: begin
        di       = frame_word(trl_tag, grant_ch_q, cnt_field);
        di_valid = 1'b1;
        if (bus.DI_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ifclk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_ch_q  <= 4'(NCH - 1);
      seq_q       <= '0;
      wcnt_q      <= '0;
      di_enable_q <= 1'b0;
`ifdef EZUSB_TX_ARB_TIMEOUT_EN
      stall_q     <= '0;
      timed_out_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_ch_q  <= grant_ch_d;
      seq_q       <= seq_d;
      wcnt_q      <= wcnt_d;
      di_enable_q <= di_enable_d;
`ifdef EZUSB_TX_ARB_TIMEOUT_EN
      stall_q     <= stall_d;
      timed_out_q <= timed_out_d;
`endif
    end
  end

  assign bus.DI        = di;
  assign bus.DI_valid  = di_valid;
  assign bus.req_ready = req_ready;
  assign bus.DI_enable = di_enable_q;
  assign grant_ch      = grant_ch_q;
  assign busy          = (state_q != ezusb_pkg::IDLE);

endmodule

// File: tb/tb_ezusb_tx_arbiter.sv
// Self-checking bench for ezusb_tx_arbiter: burst-level reference model plus directed framing checks.
module tb_ezusb_tx_arbiter;
  localparam int NCH = 4;
  localparam int BW  = 256;

  logic       ifclk   = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] grant_ch;
  logic       busy;

  ezusb_tx_arbiter_if #(.NCH(NCH)) bus ();

  ezusb_tx_arbiter #(.NCH(NCH), .BURST_WORDS(BW), .IDLE_TIMEOUT(1024)) dut (
    .ifclk    (ifclk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .grant_ch (grant_ch),
    .busy     (busy)
  );

  always #5 ifclk = ~ifclk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20) $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Stimulus: per-channel word queues {last, data}
  logic [16:0]    wq [NCH][$];
  logic [NCH-1:0] acc = '0;
  logic [15:0]    log_q [$];
  bit             rdy_rand = 1'b0;
  bit             gap_en   = 1'b0;

  task automatic push_word(input int c, input logic [15:0] d, input logic last);
    wq[c].push_back({last, d});
  endtask

  function automatic bit all_empty();
    for (int c = 0; c < NCH; c++) if (wq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] logw(input int i);
    if (i < log_q.size()) return {16'h0, log_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    bus.req_data  = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.DI_ready  = 1'b1;
    forever begin
      @(posedge ifclk);
      #1;
      if (!reset_n) begin
        for (int c = 0; c < NCH; c++) wq[c].delete();
        bus.req_valid = '0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (acc[c]) begin
            void'(wq[c].pop_front());
            bus.req_valid[c] = 1'b0;
          end
          if (!bus.req_valid[c] && wq[c].size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
            bus.req_data[16*c +: 16] = wq[c][0][15:0];
            bus.req_last[c]          = wq[c][0][16];
            bus.req_valid[c]         = 1'b1;
          end
        end
      end
      bus.DI_ready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
    end
  end

  // Reference model: burst progress tracked as header sent / body done flags
  bit             m_init = 1'b0;
  bit             m_busy, m_hdr, m_body, m_en;
  int             m_ch, m_seq, m_cnt;
  logic           e_valid;
  logic [15:0]    e_di;
  logic [NCH-1:0] e_rdy;

  always_comb begin
    e_valid = 1'b0;
    e_di    = '0;
    e_rdy   = '0;
    if (m_busy) begin
      if (!m_hdr) begin
        e_valid = 1'b1;
        e_di    = {4'hC, 4'(m_ch), 8'(m_seq)};
      end else if (!m_body) begin
        e_valid     = bus.req_valid[m_ch];
        e_di        = bus.req_data[16*m_ch +: 16];
        e_rdy[m_ch] = bus.DI_ready;
      end else begin
        e_valid = 1'b1;
        e_di    = {4'hE, 4'(m_ch), 8'(m_cnt - 1)};
      end
    end
  end

  initial begin
    forever begin
      @(posedge ifclk);
      if (!reset_n) begin
        m_init = 1'b1; m_busy = 1'b0; m_hdr = 1'b0; m_body = 1'b0; m_en = 1'b0;
        m_ch = NCH - 1; m_seq = 0; m_cnt = 0;
      end else if (m_init) begin
        bit xfer;
        bit en_n;
        xfer = e_valid && bus.DI_ready;
        en_n = m_busy || (bus.req_valid != '0);
        if (!m_busy) begin
          for (int k = 1; k <= NCH; k++) begin
            if (bus.req_valid[(m_ch + k) % NCH]) begin
              m_ch = (m_ch + k) % NCH;
              m_busy = 1'b1; m_hdr = 1'b0; m_body = 1'b0; m_cnt = 0;
              break;
            end
          end
        end else if (!m_hdr) begin
          if (bus.DI_ready) begin m_hdr = 1'b1; m_seq = (m_seq + 1) % 256; end
        end else if (!m_body) begin
          if (xfer) begin
            m_cnt++;
            if (bus.req_last[m_ch] || m_cnt == BW) m_body = 1'b1;
          end
        end else if (bus.DI_ready) begin
          m_busy = 1'b0;
        end
        m_en = en_n;
      end
    end
  end

  initial begin
    forever begin
      @(negedge ifclk);
      if (m_init) begin
        chk("DI_valid", {31'h0, bus.DI_valid}, {31'h0, e_valid});
        if (e_valid) chk("DI", {16'h0, bus.DI}, {16'h0, e_di});
        chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
        chk("busy", {31'h0, busy}, {31'h0, m_busy});
        chk("grant_ch", {28'h0, grant_ch}, 32'(m_ch));
        chk("DI_enable", {31'h0, bus.DI_enable}, {31'h0, m_en});
      end
      acc = reset_n ? (bus.req_valid & bus.req_ready) : '0;
      if (reset_n && bus.DI_valid && bus.DI_ready) log_q.push_back(bus.DI);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge ifclk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    log_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    cyc(1);
    while (!(all_empty() && bus.req_valid == '0 && !m_busy) && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_idle: still active after %0d cycles, expected idle", budget);
    end
    cyc(2);
  endtask

  initial begin
    int total;
    int n;
    cyc(3);
    chk("rst DI_valid", {31'h0, bus.DI_valid}, 32'h0);
    chk("rst DI", {16'h0, bus.DI}, 32'h0);
    chk("rst req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst busy", {31'h0, busy}, 32'h0);
    chk("rst grant_ch", {28'h0, grant_ch}, 32'h3);
    chk("rst DI_enable", {31'h0, bus.DI_enable}, 32'h0);

    // Channel 1 alone, three words
    do_reset();
    push_word(1, 16'h1110, 1'b0);
    push_word(1, 16'h1111, 1'b0);
    push_word(1, 16'h1112, 1'b1);
    wait_idle(100);
    chk("t1 len", 32'(log_q.size()), 32'd5);
    chk("t1 hdr", logw(0), 32'hC100);
    chk("t1 d0", logw(1), 32'h1110);
    chk("t1 d2", logw(3), 32'h1112);
    chk("t1 trl", logw(4), 32'hE102);
    chk("t1 grant", {28'h0, grant_ch}, 32'h1);

    // Channels 0 and 2 simultaneously, with DI_ready stalls
    do_reset();
    rdy_rand = 1'b1;
    push_word(0, 16'hA000, 1'b0); push_word(0, 16'hA001, 1'b1);
    push_word(2, 16'hB000, 1'b0); push_word(2, 16'hB001, 1'b1);
    wait_idle(200);
    rdy_rand = 1'b0;
    chk("t2 len", 32'(log_q.size()), 32'd8);
    chk("t2 hdr0", logw(0), 32'hC000);
    chk("t2 d1", logw(2), 32'hA001);
    chk("t2 trl0", logw(3), 32'hE001);
    chk("t2 hdr2", logw(4), 32'hC201);
    chk("t2 d2", logw(5), 32'hB000);
    chk("t2 trl2", logw(7), 32'hE201);

    // 300-word stream split at the burst limit
    do_reset();
    for (int i = 0; i < 300; i++) push_word(0, 16'(i), i == 299);
    wait_idle(1000);
    chk("t3 len", 32'(log_q.size()), 32'd304);
    chk("t3 hdr0", logw(0), 32'hC000);
    chk("t3 first", logw(1), 32'h0000);
    chk("t3 w255", logw(256), 32'h00FF);
    chk("t3 trl0", logw(257), 32'hE0FF);
    chk("t3 hdr1", logw(258), 32'hC001);
    chk("t3 w256", logw(259), 32'h0100);
    chk("t3 w299", logw(302), 32'd299);
    chk("t3 trl1", logw(303), 32'hE02B);

    // Reset in the middle of a data burst
    do_reset();
    for (int i = 0; i < 10; i++) push_word(0, 16'h5000 + 16'(i), i == 9);
    n = 0;
    while (log_q.size() < 6 && n < 200) begin cyc(1); n++; end
    chk("t4 reached data", {31'h0, (log_q.size() >= 6)}, 32'h1);
    reset_n = 1'b0;
    cyc(1);
    chk("t4 DI_valid", {31'h0, bus.DI_valid}, 32'h0);
    chk("t4 req_ready", 32'(bus.req_ready), 32'h0);
    chk("t4 busy", {31'h0, busy}, 32'h0);
    chk("t4 grant_ch", {28'h0, grant_ch}, 32'h3);
    reset_n = 1'b1;
    log_q.delete();
    push_word(1, 16'h7777, 1'b1);
    wait_idle(100);
    chk("t4 len", 32'(log_q.size()), 32'd3);
    chk("t4 hdr seq0", logw(0), 32'hC100);
    chk("t4 trl", logw(2), 32'hE100);

    // Randomized traffic with valid gaps and DI_ready stalls
    for (int r = 0; r < 2; r++) begin
      do_reset();
      rdy_rand = 1'b1;
      gap_en   = 1'b1;
      total    = 0;
      for (int m = 0; m < 6; m++) begin
        for (int c = 0; c < NCH; c++) begin
          int len;
          len = int'($urandom_range(5, 1));
          for (int w = 0; w < len; w++) push_word(c, 16'($urandom), w == len - 1);
          total += len + 2;
        end
      end
      wait_idle(5000);
      chk("rand word count", 32'(log_q.size()), 32'(total));
      rdy_rand = 1'b0;
      gap_en   = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
